test_monitor: RTL and testbench
===============================

Name: test_monitor

Overview:
Synthesizable, parametrised end-of-test monitor for the RV32 pipelined core. It watches the retiring PC stream and data-memory writes, and decides PASS/FAIL/TIMEOUT/HANG from any of several pass/fail addresses, a tohost write, a cycle budget, or a stuck PC. It drives a sticky status word and counters, so the same verdict logic serves simulation benches and on-board runs (status to LEDs/UART).

Parameters:
PC_WIDTH, 32, width of PC and data-memory address/data
NUM_PASS, 2, number of pass addresses compared (>=1)
NUM_FAIL, 2, number of fail addresses compared (>=1)
TIMEOUT_CYCLES, 4000, cycle budget in RUN; 0 disables timeout
HANG_CYCLES, 64, consecutive retires at an unchanged PC that declare HANG; 0 disables
TOHOST_EN, 1, enables tohost write detection
TOHOST_ADDR, 32'h0000_1000, data address of tohost
CNT_WIDTH, 32, width of cycle and retire counters

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
arm  in  1  single-cycle pulse: clear counters, enter RUN
pc  in  PC_WIDTH  PC of the retiring instruction
pc_valid  in  1  qualifies pc (one retire per cycle max)
pass_addr  in  NUM_PASS*PC_WIDTH  flattened pass addresses; entry k = [k*PC_WIDTH +: PC_WIDTH]
fail_addr  in  NUM_FAIL*PC_WIDTH  flattened fail addresses
dm_wen  in  1  data-memory write strobe
dm_addr  in  PC_WIDTH  data-memory write address
dm_wdata  in  PC_WIDTH  data-memory write data
done  out  1  high in any terminal state
status  out  3  test_monitor_pkg::status_e
fail_code  out  PC_WIDTH  tohost payload (wdata>>1) or fail-address index+1
cycle_count  out  CNT_WIDTH  cycles spent in RUN
retire_count  out  CNT_WIDTH  pc_valid cycles seen in RUN
last_pc  out  PC_WIDTH  most recent valid pc

Behaviour:
- Reset: status=IDLE, done=0, fail_code=0, cycle_count=0, retire_count=0, last_pc=0, hang counter=0. rst overrides every other input in the same cycle.
- States: IDLE(0), RUN(1), PASS(2), FAIL(3), TIMEOUT(4), HANG(5). IDLE->RUN on arm. Terminal states are sticky and ignore all inputs except arm. arm in any state clears counters, fail_code and the hang counter, and enters RUN on the next cycle. arm in RUN restarts the test.
- Events apply only in RUN and are registered: status/done change on the clock edge that ends the cycle in which the event is present (1-cycle latency).
- pc match: pc_valid && pc==fail_addr[k] -> FAIL, fail_code=k+1 (lowest k wins); pc==pass_addr[k] -> PASS.
- tohost: TOHOST_EN && dm_wen && dm_addr==TOHOST_ADDR && dm_wdata[0]. wdata==1 -> PASS; otherwise FAIL with fail_code=dm_wdata>>1. Writes with wdata[0]=0 are ignored.
- Priority in the same cycle: fail-pc > tohost-fail > pass-pc > tohost-pass > TIMEOUT > HANG.
- cycle_count increments every RUN cycle, including the event cycle. TIMEOUT is taken when cycle_count==TIMEOUT_CYCLES-1 and no higher-priority event occurs, so exactly TIMEOUT_CYCLES RUN cycles elapse.
- retire_count increments on each pc_valid in RUN. last_pc updates on each pc_valid, and also in IDLE.
- Hang: on pc_valid, if pc==last_pc then increment the hang counter, else clear it. HANG is taken when the counter reaches HANG_CYCLES-1 on a matching retire. A pass/fail match at the same pc takes precedence, so self-loop pass stubs resolve to PASS.
- Counters saturate at all-ones and never wrap.
- pass and fail address lists may overlap; fail wins.

Decomposition:
- test_monitor_pkg: status_e enum (3-bit, values above), priority constants, helper function for the tohost decode.
- Sub-module addr_match #(N, W): compares pc against N flattened addresses and returns hit plus lowest-index encoding. Instantiated twice, once for pass and once for fail.

Test Plan:
- Reset, arm, then pc_valid with pc=0x100 for 10 cycles where pass_addr[1]=0x100 -> status=PASS one cycle after the first match, done=1, retire_count=1.
- Same cycle: pc=0x200 equal to both pass_addr[0] and fail_addr[1] -> status=FAIL, fail_code=2.
- tohost write dm_addr=0x1000, wdata=0x0000_0007 -> FAIL, fail_code=3. A later write with wdata=1 leaves status at FAIL (sticky).
- TIMEOUT_CYCLES=4000 with no events -> status=TIMEOUT after exactly 4000 RUN cycles, cycle_count=3999 at the transition edge. TIMEOUT_CYCLES=0 -> still RUN after 10000 cycles.
- HANG_CYCLES=64, pc=0x44 repeated with pc_valid -> HANG on the 64th identical retire. One intervening pc=0x48 retire clears the hang count.
- PASS reached, then arm pulse -> RUN, counters 0, fail_code 0. rst asserted mid-RUN together with arm -> IDLE.

Source files
------------

// File: rtl/test_monitor_pkg.sv
// Shared types for the end-of-test monitor.
//   status_e : externally visible verdict word (IDLE/RUN/PASS/FAIL/TIMEOUT/HANG)
//   event_e  : per-cycle event kinds; a larger encoding wins when several coincide
//   tohost_e : decoded tohost write, produced by tohost_decode()
package test_monitor_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRun     = 3'd1,
    StPass    = 3'd2,
    StFail    = 3'd3,
    StTimeout = 3'd4,
    StHang    = 3'd5
  } status_e;

  // Encoding doubles as priority: fail-pc > tohost-fail > pass-pc > tohost-pass > timeout > hang.
  typedef enum logic [2:0] {
    EvNone       = 3'd0,
    EvHang       = 3'd1,
    EvTimeout    = 3'd2,
    EvTohostPass = 3'd3,
    EvPassPc     = 3'd4,
    EvTohostFail = 3'd5,
    EvFailPc     = 3'd6
  } event_e;

  typedef enum logic [1:0] {
    ThNone = 2'd0,
    ThPass = 2'd1,
    ThFail = 2'd2
  } tohost_e;

  // A tohost write only counts when bit 0 of the data is set; a value of exactly 1 means pass.
  function automatic tohost_e tohost_decode(input logic wen, input logic addr_hit,
                                            input logic wdata_lsb, input logic wdata_is_one);
    if (!(wen && addr_hit && wdata_lsb)) return ThNone;
    return wdata_is_one ? ThPass : ThFail;
  endfunction

endpackage

// File: rtl/addr_match.sv
// Compares one address against N flattened candidate addresses.
//   addr  : address under test
//   addrs : N entries, entry k at [k*W +: W]
//   hit   : any entry equal to addr
//   idx   : lowest matching entry index (0 when no hit)
module addr_match #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 32,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [W-1:0]    addr,
  input  logic [N*W-1:0]  addrs,
  output logic            hit,
  output logic [IdxW-1:0] idx
);

  // Scan from the top down so the lowest matching index is written last.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (addr == addrs[k*W +: W]) begin
        hit = 1'b1;
        idx = IdxW'(k);
      end
    end
  end

endmodule

// File: rtl/test_monitor.sv
// End-of-test monitor for the RV32 pipelined core. Watches retiring PCs and data-memory writes
// and latches a sticky verdict.
//   clk, rst          : clock, synchronous active-high reset
//   arm               : pulse; clears counters/fail_code and (re)starts RUN
//   pc, pc_valid      : retiring instruction PC
//   pass_addr/fail_addr : flattened address lists
//   dm_wen/addr/wdata : data-memory write port (tohost detection)
//   done, status      : terminal flag and verdict (test_monitor_pkg::status_e)
//   fail_code         : tohost payload (wdata>>1) or fail index+1
//   cycle_count, retire_count, last_pc : run statistics
module test_monitor
  import test_monitor_pkg::*;
#(
  parameter int unsigned             PC_WIDTH       = 32,
  parameter int unsigned             NUM_PASS       = 2,
  parameter int unsigned             NUM_FAIL       = 2,
  parameter int unsigned             TIMEOUT_CYCLES = 4000,
  parameter int unsigned             HANG_CYCLES    = 64,
  parameter bit                      TOHOST_EN      = 1'b1,
  parameter logic [PC_WIDTH-1:0]     TOHOST_ADDR    = PC_WIDTH'(32'h0000_1000),
  parameter int unsigned             CNT_WIDTH      = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         arm,
  input  logic [PC_WIDTH-1:0]          pc,
  input  logic                         pc_valid,
  input  logic [NUM_PASS*PC_WIDTH-1:0] pass_addr,
  input  logic [NUM_FAIL*PC_WIDTH-1:0] fail_addr,
  input  logic                         dm_wen,
  input  logic [PC_WIDTH-1:0]          dm_addr,
  input  logic [PC_WIDTH-1:0]          dm_wdata,
  output logic                         done,
  output status_e                      status,
  output logic [PC_WIDTH-1:0]          fail_code,
  output logic [CNT_WIDTH-1:0]         cycle_count,
  output logic [CNT_WIDTH-1:0]         retire_count,
  output logic [PC_WIDTH-1:0]          last_pc
);

  localparam int unsigned PassIdxW = (NUM_PASS > 1) ? $clog2(NUM_PASS) : 1;
  localparam int unsigned FailIdxW = (NUM_FAIL > 1) ? $clog2(NUM_FAIL) : 1;
  localparam logic [CNT_WIDTH-1:0] TimeoutLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HangLast    = CNT_WIDTH'(HANG_CYCLES - 1);

  status_e                status_q, status_d;
  logic [PC_WIDTH-1:0]    fail_code_q, fail_code_d;
  logic [CNT_WIDTH-1:0]   cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0]   retire_q, retire_d;
  logic [CNT_WIDTH-1:0]   hang_q, hang_d;
  logic [PC_WIDTH-1:0]    last_pc_q, last_pc_d;

  logic                   pass_hit, fail_hit;
  logic [PassIdxW-1:0]    pass_idx;
  logic [FailIdxW-1:0]    fail_idx;
  logic                   unused_pass_idx;
  tohost_e                th;
  logic                   same_pc, timeout_hit, hang_hit;
  logic [CNT_WIDTH-1:0]   hang_inc;
  event_e                 ev;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

  addr_match #(
    .N (NUM_PASS),
    .W (PC_WIDTH)
  ) u_pass_match (
    .addr  (pc),
    .addrs (pass_addr),
    .hit   (pass_hit),
    .idx   (pass_idx)
  );

  addr_match #(
    .N (NUM_FAIL),
    .W (PC_WIDTH)
  ) u_fail_match (
    .addr  (pc),
    .addrs (fail_addr),
    .hit   (fail_hit),
    .idx   (fail_idx)
  );

  assign unused_pass_idx = ^pass_idx;

  always_comb begin
    th = ThNone;
    if (TOHOST_EN) begin
      th = tohost_decode(dm_wen, dm_addr == TOHOST_ADDR, dm_wdata[0],
                         dm_wdata == PC_WIDTH'(1));
    end
  end

  assign same_pc     = pc_valid && (pc == last_pc_q);
  assign hang_inc    = sat_inc(hang_q);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_q == TimeoutLast);
  // hang_inc is the count after this matching retire; HANG once it reaches HANG_CYCLES-1.
  assign hang_hit    = (HANG_CYCLES != 0) && same_pc && (hang_inc >= HangLast);

  always_comb begin
    ev = EvNone;
    if (pc_valid && fail_hit)      ev = EvFailPc;
    else if (th == ThFail)         ev = EvTohostFail;
    else if (pc_valid && pass_hit) ev = EvPassPc;
    else if (th == ThPass)         ev = EvTohostPass;
    else if (timeout_hit)          ev = EvTimeout;
    else if (hang_hit)             ev = EvHang;
  end

  always_comb begin
    status_d    = status_q;
    fail_code_d = fail_code_q;
    cycle_d     = cycle_q;
    retire_d    = retire_q;
    hang_d      = hang_q;
    last_pc_d   = last_pc_q;
    if (arm) begin
      status_d    = StRun;
      fail_code_d = '0;
      cycle_d     = '0;
      retire_d    = '0;
      hang_d      = '0;
      if (pc_valid) last_pc_d = pc;
    end else begin
      case (status_q)
        StIdle: begin
          if (pc_valid) last_pc_d = pc;
        end
        StRun: begin
          cycle_d = sat_inc(cycle_q);
          if (pc_valid) begin
            retire_d  = sat_inc(retire_q);
            last_pc_d = pc;
            hang_d    = same_pc ? hang_inc : '0;
          end
          case (ev)
            EvFailPc: begin
              status_d    = StFail;
              fail_code_d = PC_WIDTH'(fail_idx) + PC_WIDTH'(1);
            end
            EvTohostFail: begin
              status_d    = StFail;
              fail_code_d = dm_wdata >> 1;
            end
            EvPassPc, EvTohostPass: status_d = StPass;
            EvTimeout:              status_d = StTimeout;
            EvHang:                 status_d = StHang;
            default: ;
          endcase
        end
        default: ;  // terminal states hold until arm
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q    <= StIdle;
      fail_code_q <= '0;
      cycle_q     <= '0;
      retire_q    <= '0;
      hang_q      <= '0;
      last_pc_q   <= '0;
    end else begin
      status_q    <= status_d;
      fail_code_q <= fail_code_d;
      cycle_q     <= cycle_d;
      retire_q    <= retire_d;
      hang_q      <= hang_d;
      last_pc_q   <= last_pc_d;
    end
  end

  assign status       = status_q;
  assign done         = (status_q != StIdle) && (status_q != StRun);
  assign fail_code    = fail_code_q;
  assign cycle_count  = cycle_q;
  assign retire_count = retire_q;
  assign last_pc      = last_pc_q;

endmodule

// File: tb/tb_test_monitor.sv
module tb_test_monitor;
  import test_monitor_pkg::*;

  logic        clk = 1'b0;
  logic        rst, arm, pc_valid, dm_wen;
  logic [31:0] pc, dm_addr, dm_wdata;
  logic [63:0] pass_addr, fail_addr;

  logic        done, nt_done;
  status_e     status, nt_status;
  logic [31:0] fail_code, cycle_count, retire_count, last_pc;
  logic [31:0] nt_fail_code, nt_cycle, nt_retire, nt_last_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  test_monitor dut (
    .clk (clk), .rst (rst), .arm (arm), .pc (pc), .pc_valid (pc_valid),
    .pass_addr (pass_addr), .fail_addr (fail_addr),
    .dm_wen (dm_wen), .dm_addr (dm_addr), .dm_wdata (dm_wdata),
    .done (done), .status (status), .fail_code (fail_code),
    .cycle_count (cycle_count), .retire_count (retire_count), .last_pc (last_pc)
  );

  // Same stimulus, timeout disabled.
  test_monitor #(.TIMEOUT_CYCLES (0)) dut_nt (
    .clk (clk), .rst (rst), .arm (arm), .pc (pc), .pc_valid (pc_valid),
    .pass_addr (pass_addr), .fail_addr (fail_addr),
    .dm_wen (dm_wen), .dm_addr (dm_addr), .dm_wdata (dm_wdata),
    .done (nt_done), .status (nt_status), .fail_code (nt_fail_code),
    .cycle_count (nt_cycle), .retire_count (nt_retire), .last_pc (nt_last_pc)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    arm = 1'b0; pc_valid = 1'b0; pc = '0; dm_wen = 1'b0; dm_addr = '0; dm_wdata = '0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    cyc(1);
    arm = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; arm = 1'b1; pc_valid = 1'b1; pc = 32'h55;
    cyc(2);
    checks++; if (status !== StIdle) begin errors++; $display("FAIL reset_status got %0d want %0d", status, StIdle); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (last_pc !== 32'h0) begin errors++; $display("FAIL reset_last_pc got %h want 0", last_pc); end
    checks++; if (cycle_count !== 32'd0 || retire_count !== 32'd0 || fail_code !== 32'd0) begin
      errors++; $display("FAIL reset_counters got %0d/%0d/%0d want 0/0/0", cycle_count, retire_count, fail_code);
    end
    rst = 1'b0; idle_inputs();
    pc_valid = 1'b1; pc = 32'h24;
    cyc(1);
    pc_valid = 1'b0;
    checks++; if (last_pc !== 32'h24 || status !== StIdle) begin
      errors++; $display("FAIL idle_last_pc got %h/%0d want 24/%0d", last_pc, status, StIdle);
    end
  endtask

  task automatic test_pass();
    do_arm();
    checks++; if (status !== StRun || cycle_count !== 32'd0) begin
      errors++; $display("FAIL arm_run got %0d/%0d want %0d/0", status, cycle_count, StRun);
    end
    pc_valid = 1'b1; pc = 32'h100;
    cyc(1);
    checks++; if (status !== StPass || done !== 1'b1) begin
      errors++; $display("FAIL pass_status got %0d/%0b want %0d/1", status, done, StPass);
    end
    checks++; if (retire_count !== 32'd1 || cycle_count !== 32'd1) begin
      errors++; $display("FAIL pass_counts got %0d/%0d want 1/1", retire_count, cycle_count);
    end
    cyc(9);
    pc_valid = 1'b0;
    checks++; if (status !== StPass || retire_count !== 32'd1 || fail_code !== 32'd0) begin
      errors++; $display("FAIL pass_sticky got %0d/%0d/%0d want %0d/1/0", status, retire_count, fail_code, StPass);
    end
  endtask

  task automatic test_overlap();
    do_arm();
    checks++; if (status !== StRun || retire_count !== 32'd0 || cycle_count !== 32'd0) begin
      errors++; $display("FAIL rearm_from_pass got %0d/%0d/%0d want %0d/0/0", status, retire_count, cycle_count, StRun);
    end
    pc_valid = 1'b1; pc = 32'h200;
    cyc(1);
    pc_valid = 1'b0;
    checks++; if (status !== StFail || fail_code !== 32'd2) begin
      errors++; $display("FAIL overlap_fail got %0d/%0d want %0d/2", status, fail_code, StFail);
    end
  endtask

  task automatic test_tohost();
    do_arm();
    dm_wen = 1'b1; dm_addr = 32'h1000; dm_wdata = 32'h6;
    cyc(1);
    checks++; if (status !== StRun) begin errors++; $display("FAIL tohost_even_ignored got %0d want %0d", status, StRun); end
    dm_wdata = 32'h7;
    cyc(1);
    checks++; if (status !== StFail || fail_code !== 32'd3) begin
      errors++; $display("FAIL tohost_fail got %0d/%0d want %0d/3", status, fail_code, StFail);
    end
    dm_wdata = 32'h1;
    cyc(1);
    checks++; if (status !== StFail || fail_code !== 32'd3) begin
      errors++; $display("FAIL tohost_sticky got %0d/%0d want %0d/3", status, fail_code, StFail);
    end
    dm_wen = 1'b0;
    do_arm();
    checks++; if (status !== StRun || fail_code !== 32'd0) begin
      errors++; $display("FAIL rearm_clears_code got %0d/%0d want %0d/0", status, fail_code, StRun);
    end
    dm_wen = 1'b1; dm_wdata = 32'h1;
    cyc(1);
    dm_wen = 1'b0;
    checks++; if (status !== StPass || fail_code !== 32'd0) begin
      errors++; $display("FAIL tohost_pass got %0d/%0d want %0d/0", status, fail_code, StPass);
    end
  endtask

  task automatic test_rst_with_arm();
    do_arm();
    pc_valid = 1'b1; pc = 32'h10;
    cyc(3);
    checks++; if (status !== StRun || retire_count !== 32'd3) begin
      errors++; $display("FAIL run_retires got %0d/%0d want %0d/3", status, retire_count, StRun);
    end
    rst = 1'b1; arm = 1'b1;
    cyc(1);
    rst = 1'b0; idle_inputs();
    checks++; if (status !== StIdle || cycle_count !== 32'd0 || retire_count !== 32'd0 || last_pc !== 32'd0) begin
      errors++; $display("FAIL rst_over_arm got %0d/%0d/%0d/%h want %0d/0/0/0",
                         status, cycle_count, retire_count, last_pc, StIdle);
    end
  endtask

  task automatic test_timeout();
    do_arm();
    cyc(3999);
    checks++; if (status !== StRun || cycle_count !== 32'd3999) begin
      errors++; $display("FAIL pre_timeout got %0d/%0d want %0d/3999", status, cycle_count, StRun);
    end
    cyc(1);
    checks++; if (status !== StTimeout || cycle_count !== 32'd4000 || done !== 1'b1) begin
      errors++; $display("FAIL timeout got %0d/%0d/%0b want %0d/4000/1", status, cycle_count, done, StTimeout);
    end
    cyc(6000);
    checks++; if (status !== StTimeout || cycle_count !== 32'd4000) begin
      errors++; $display("FAIL timeout_sticky got %0d/%0d want %0d/4000", status, cycle_count, StTimeout);
    end
    checks++; if (nt_status !== StRun || nt_cycle !== 32'd10000 || nt_done !== 1'b0) begin
      errors++; $display("FAIL no_timeout got %0d/%0d/%0b want %0d/10000/0", nt_status, nt_cycle, nt_done, StRun);
    end
    checks++; if (nt_retire !== 32'd0 || nt_fail_code !== 32'd0 || nt_last_pc !== 32'd0) begin
      errors++; $display("FAIL no_timeout_stats got %0d/%0d/%h want 0/0/0", nt_retire, nt_fail_code, nt_last_pc);
    end
  endtask

  task automatic test_hang();
    do_arm();
    pc_valid = 1'b1; pc = 32'h44;
    cyc(40);
    pc = 32'h48;
    cyc(1);
    pc = 32'h44;
    cyc(63);
    checks++; if (status !== StRun) begin errors++; $display("FAIL hang_cleared got %0d want %0d", status, StRun); end
    cyc(1);
    pc_valid = 1'b0;
    checks++; if (status !== StHang || done !== 1'b1) begin
      errors++; $display("FAIL hang got %0d/%0b want %0d/1", status, done, StHang);
    end
    checks++; if (retire_count !== 32'd105 || last_pc !== 32'h44) begin
      errors++; $display("FAIL hang_stats got %0d/%h want 105/44", retire_count, last_pc);
    end
  endtask

  task automatic test_self_loop_pass();
    do_arm();
    pc_valid = 1'b1; pc = 32'h30;
    cyc(1);
    pc = 32'h100;
    cyc(1);
    pc_valid = 1'b0;
    checks++; if (status !== StPass) begin errors++; $display("FAIL pass_after_run got %0d want %0d", status, StPass); end
  endtask

  initial begin
    pass_addr = {32'h100, 32'h200};
    fail_addr = {32'h200, 32'h300};
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_pass();
    test_overlap();
    test_tohost();
    test_rst_with_arm();
    test_timeout();
    test_hang();
    test_self_loop_pass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
